// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and flag-vector layout for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // Bit positions inside the registered flag vector.
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int NFLG  = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: loads on i_start, then takes exactly WIDTH cycles.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;

  // Low half starts as the multiplier and is consumed LSB-first as the
  // partial product shifts in from the top.
  always_comb begin
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    if (r_prod[0]) w_sum = w_sum + {1'b0, r_mcand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= i_a;
      r_prod  <= {{WIDTH{1'b0}}, i_b};
      r_cnt   <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_busy    = (r_cnt != '0);
  // High during the cycle whose closing edge performs the last step.
  assign o_done    = (r_cnt == CW'(1));
  assign o_product = r_prod;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, one op in flight, multi-cycle MUL.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             CARRY,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);
  localparam int M = WIDTH - 1;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_out;
  logic [NFLG-1:0]    r_flags;
  logic               r_sel_mul;

  logic               w_accept, w_is_mul;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v;
  logic [NFLG-1:0]    w_flags;
  logic               w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_mul = (OP == OP_MUL);
  assign w_sh     = B[SHW-1:0];
  assign w_accept = in_valid && in_ready;

  // Single-cycle datapath; MUL is handled by the sequential multiplier.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        {w_c, w_res} = {1'b0, A} + {1'b0, B};
        w_v = (A[M] == B[M]) && (w_res[M] != A[M]);
      end
      OP_SUB: begin
        {w_c, w_res} = {1'b0, A} - {1'b0, B};
        w_v = (A[M] != B[M]) && (w_res[M] != A[M]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      // Extra bit beyond the edge catches the last bit shifted out (0 for s=0).
      OP_SHL: {w_c, w_res} = {1'b0, A} << w_sh;
      OP_SHR: {w_res, w_c} = {A, 1'b0} >> w_sh;
      default: ;
    endcase
    w_flags        = '0;
    w_flags[FLG_C] = w_c;
    w_flags[FLG_Z] = (w_res == '0);
    w_flags[FLG_N] = w_res[M];
    w_flags[FLG_V] = w_v;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_mul_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? (w_is_mul ? S_BUSY : S_DONE) : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_flags   <= '0;
      r_sel_mul <= 1'b0;
    end else if (w_accept) begin
      r_sel_mul <= w_is_mul;
      if (!w_is_mul) begin
        r_out   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (A),
    .i_b       (B),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // The multiplier's product register is held until the next MUL starts, so it
  // drives the outputs directly once its op is the one being presented.
  always_comb begin
    if (r_sel_mul) begin
      OUT    = w_prod[WIDTH-1:0];
      OUT_HI = w_prod[2*WIDTH-1:WIDTH];
      CARRY  = |w_prod[2*WIDTH-1:WIDTH];
      ZERO   = (w_prod == '0);
      NEG    = w_prod[2*WIDTH-1];
      OVF    = 1'b0;
    end else begin
      OUT    = r_out;
      OUT_HI = '0;
      CARRY  = r_flags[FLG_C];
      ZERO   = r_flags[FLG_Z];
      NEG    = r_flags[FLG_N];
      OVF    = r_flags[FLG_V];
    end
  end

  logic w_unused;
  assign w_unused = w_mul_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8): handshake timing, flags, MUL latency, reset.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] A = '0, B = '0;
  logic [2:0] OP = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] OUT, OUT_HI;
  logic       CARRY, ZERO, NEG, OVF;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
    .OUT(OUT), .OUT_HI(OUT_HI), .CARRY(CARRY), .ZERO(ZERO), .NEG(NEG), .OVF(OVF)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = 1'b1; A = a; B = b; OP = op;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({OUT, OUT_HI, CARRY, ZERO, NEG, OVF} !== 20'h0) begin n_err++;
      $display("FAIL reset_outputs got %h/%h c%b z%b n%b v%b want all 0", OUT, OUT_HI, CARRY, ZERO, NEG, OVF); end
    rst = 1'b0;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    issue(8'hF0, 8'h20, 3'b000);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_latency out_valid got %b want 1", out_valid); end
    n_cmp++; if ({OUT, CARRY, ZERO, OVF} !== {8'h10, 3'b100}) begin n_err++;
      $display("FAIL add_f0_20 got %h c%b z%b v%b want 10 c1 z0 v0", OUT, CARRY, ZERO, OVF); end
    issue(8'h7F, 8'h01, 3'b000);
    n_cmp++; if ({OUT, CARRY, NEG, OVF} !== {8'h80, 3'b011}) begin n_err++;
      $display("FAIL add_7f_01 got %h c%b n%b v%b want 80 c0 n1 v1", OUT, CARRY, NEG, OVF); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sub;
    out_ready = 1'b1;
    issue(8'h05, 8'h07, 3'b001);
    n_cmp++; if ({OUT, CARRY, NEG, OVF} !== {8'hFE, 3'b110}) begin n_err++;
      $display("FAIL sub_05_07 got %h c%b n%b v%b want fe c1 n1 v0", OUT, CARRY, NEG, OVF); end
    issue(8'h80, 8'h01, 3'b001);
    n_cmp++; if ({OUT, CARRY, OVF} !== {8'h7F, 2'b01}) begin n_err++;
      $display("FAIL sub_80_01 got %h c%b v%b want 7f c0 v1", OUT, CARRY, OVF); end
    issue(8'h33, 8'h33, 3'b001);
    n_cmp++; if ({OUT, CARRY, ZERO, OVF} !== {8'h00, 3'b010}) begin n_err++;
      $display("FAIL sub_33_33 got %h c%b z%b v%b want 00 c0 z1 v0", OUT, CARRY, ZERO, OVF); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_logic_shift;
    out_ready = 1'b1;
    issue(8'hF0, 8'h3C, 3'b010);
    n_cmp++; if ({OUT, CARRY} !== {8'h30, 1'b0}) begin n_err++; $display("FAIL and got %h c%b want 30 c0", OUT, CARRY); end
    issue(8'hF0, 8'h0F, 3'b011);
    n_cmp++; if ({OUT, NEG, ZERO} !== {8'hFF, 2'b10}) begin n_err++; $display("FAIL or got %h n%b z%b want ff n1 z0", OUT, NEG, ZERO); end
    issue(8'h81, 8'h00, 3'b101);
    n_cmp++; if ({OUT, CARRY} !== {8'h81, 1'b0}) begin n_err++; $display("FAIL shl_by0 got %h c%b want 81 c0", OUT, CARRY); end
    issue(8'hC1, 8'h07, 3'b110);
    n_cmp++; if ({OUT, CARRY} !== {8'h01, 1'b1}) begin n_err++; $display("FAIL shr_by7 got %h c%b want 01 c1", OUT, CARRY); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    out_ready = 1'b1;
    issue(8'hFF, 8'hFF, 3'b111);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if ({in_ready, out_valid} !== 2'b00) begin n_err++;
        $display("FAIL mul_busy cycle %0d got rdy%b vld%b want 0 0", i + 1, in_ready, out_valid); end
      @(posedge clk); #1;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_latency out_valid got %b want 1", out_valid); end
    n_cmp++; if ({OUT_HI, OUT, CARRY, ZERO, NEG, OVF} !== {16'hFE01, 4'b1010}) begin n_err++;
      $display("FAIL mul_ff_ff got %h%h c%b z%b n%b v%b want fe01 c1 z0 n1 v0", OUT_HI, OUT, CARRY, ZERO, NEG, OVF); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_drain out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    issue(8'h81, 8'h3C, 3'b100);
    n_cmp++; if ({out_valid, in_ready, OUT, OUT_HI} !== {2'b11, 8'hBD, 8'h00}) begin n_err++;
      $display("FAIL b2b_xor got vld%b rdy%b %h hi%h want 1 1 bd 00", out_valid, in_ready, OUT, OUT_HI); end
    issue(8'h81, 8'h03, 3'b101);
    n_cmp++; if ({out_valid, OUT, CARRY} !== {1'b1, 8'h08, 1'b0}) begin n_err++;
      $display("FAIL b2b_shl got vld%b %h c%b want 1 08 c0", out_valid, OUT, CARRY); end
    issue(8'h81, 8'h01, 3'b110);
    n_cmp++; if ({out_valid, OUT, CARRY} !== {1'b1, 8'h40, 1'b1}) begin n_err++;
      $display("FAIL b2b_shr got vld%b %h c%b want 1 40 c1", out_valid, OUT, CARRY); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 3'b000);
    A = 8'h10; B = 8'h01; OP = 3'b001;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({out_valid, in_ready, OUT, CARRY, ZERO} !== {2'b10, 8'h46, 2'b00}) begin n_err++;
        $display("FAIL bp_hold cycle %0d got vld%b rdy%b %h c%b z%b want 1 0 46 c0 z0", i, out_valid, in_ready, OUT, CARRY, ZERO); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_comb got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, OUT} !== {1'b1, 8'h0F}) begin n_err++;
      $display("FAIL bp_next got vld%b %h want 1 0f", out_valid, OUT); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul;
    out_ready = 1'b1;
    issue(8'h12, 8'h34, 3'b111);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmul_busy in_ready got %b want 0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++;
      $display("FAIL rmul_hs got vld%b rdy%b want 0 1", out_valid, in_ready); end
    n_cmp++; if ({OUT, OUT_HI, CARRY, ZERO, NEG, OVF} !== 20'h0) begin n_err++;
      $display("FAIL rmul_outputs got %h/%h c%b z%b n%b v%b want all 0", OUT, OUT_HI, CARRY, ZERO, NEG, OVF); end
    rst = 1'b0;
    issue(8'h01, 8'h01, 3'b000);
    n_cmp++; if ({out_valid, OUT, OUT_HI} !== {1'b1, 8'h02, 8'h00}) begin n_err++;
      $display("FAIL rmul_add got vld%b %h hi%h want 1 02 00", out_valid, OUT, OUT_HI); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a 3-bit opcode (XOR, shifts, multi-cycle multiply), and a full flag set (carry, zero, negative, overflow).
- Sits between the operand-select logic and the writeback register.
- Holds one operation in flight.
- Results stay stable until the consumer accepts them.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- OP  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (unsigned).
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- OUT  out  WIDTH  result; low half for MUL.
- OUT_HI  out  WIDTH  high half of MUL product; 0 for all other ops.
- CARRY  out  1  carry/borrow/shift-out flag.
- ZERO  out  1  OUT==0 (for MUL: the full 2*WIDTH product == 0).
- NEG  out  1  OUT[WIDTH-1] (MUL: OUT_HI[WIDTH-1]).
- OVF  out  1  signed overflow, ADD/SUB only, else 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State -> IDLE; in_ready=1; out_valid=0.
  - OUT, OUT_HI, CARRY, ZERO, NEG, OVF all 0.
  - Any in-progress MUL is discarded.
- Acceptance: an operation is accepted on a rising edge with in_valid && in_ready. A, B and OP are captured at that edge; later changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of a non-MUL op -> DONE. Results registered at the accept edge, so out_valid=1 on the next cycle (latency 1).
  - IDLE, accept of MUL -> BUSY. Multiplier runs a shift-add loop for exactly WIDTH cycles, then -> DONE. out_valid asserts WIDTH+1 cycles after the accept edge.
  - BUSY: in_ready=0; out_valid=0.
  - DONE: out_valid=1; outputs held stable while out_ready=0.
  - DONE with out_ready=1 and no new accept -> IDLE.
  - DONE with out_ready=1 and in_valid=1: new op accepted in the same cycle (in_ready = out_ready in DONE). Non-MUL stays in DONE with new results (throughput 1/cycle); MUL goes to BUSY.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from out_ready only.
- Arithmetic rules:
  - ADD: {CARRY,OUT} = A+B (WIDTH+1 bits). OVF = (A[msb]==B[msb]) && (OUT[msb]!=A[msb]).
  - SUB: OUT = A-B mod 2^WIDTH. CARRY = borrow (A<B unsigned). OVF = (A[msb]!=B[msb]) && (OUT[msb]!=A[msb]).
  - AND/OR/XOR: bitwise; CARRY=0.
  - SHL by s=B[SHW-1:0]: OUT = A<<s; CARRY = last bit shifted out (A[WIDTH-s]), 0 when s=0.
  - SHR by s: OUT = A>>s; CARRY = A[s-1], 0 when s=0.
  - MUL: {OUT_HI,OUT} = A*B unsigned; CARRY = |OUT_HI.
- Boundary conditions:
  - rst asserted during BUSY or DONE: the result is lost and out_valid drops at that edge.
  - in_valid with in_ready=0: not accepted. The producer must hold its inputs.
  - out_ready while out_valid=0: no effect.
  - OP values are fully decoded; there is no illegal code.

Decomposition:
- Package alu_seq_pkg:
  - Opcode localparams OP_ADD..OP_MUL.
  - State enum {IDLE, BUSY, DONE}.
  - Flag-index constants.
- Sub-module alu_mul_seq (parametrised WIDTH):
  - Interface: start, A, B in; busy, done, product[2*WIDTH-1:0] out.
  - Internals: WIDTH-cycle shift-add with a down-counter.
  - Instantiated once; the top holds the FSM, the single-cycle datapath and the flags.

Test Plan (WIDTH=8):
- ADD 0xF0+0x20, out_ready=1:
  - out_valid 1 cycle after accept.
  - OUT=0x10, CARRY=1, ZERO=0, OVF=0.
  - 0x7F+0x01 gives OUT=0x80, OVF=1, NEG=1.
- SUB 0x05-0x07: OUT=0xFE, CARRY=1, NEG=1. SUB 0x80-0x01: OUT=0x7F, OVF=1. SUB 0x33-0x33: ZERO=1.
- MUL 0xFF*0xFF:
  - in_ready=0 for 8 BUSY cycles.
  - out_valid on cycle 9 after accept.
  - OUT=0x01, OUT_HI=0xFE, CARRY=1.
- Back-to-back: stream XOR, SHL (A=0x81, B=3), SHR (A=0x81, B=1) with out_ready=1.
  - One result per cycle: 0x81^B, then OUT=0x08/CARRY=0, then OUT=0x40/CARRY=1.
- Backpressure: out_ready=0 for 5 cycles after a result.
  - OUT and flags stable; in_ready=0.
  - Raising out_ready together with in_valid accepts the next op in the same cycle.
- rst asserted mid-MUL (cycle 4 of BUSY): next cycle out_valid=0, in_ready=1, all outputs 0. A following ADD 1+1 returns 0x02.
